// File: rtl/btle_rx_pdu_streamer_pkg.sv
// Shared types and helpers for the BLE receive PDU streamer:
// FSM state encoding, default geometry and the saturating counter step.
package btle_rx_pdu_streamer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int HDR_OCTETS_C = 2;
   localparam int MEM_ADDR_W_C = 6;

   // Adds one unless the low 'width' bits are already all ones.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] max_v;
      max_v = 32'hFFFF_FFFF >> (32 - width);
      if (val == max_v) begin
         sat_inc = val;
      end else begin
         sat_inc = val + 32'd1;
      end
   endfunction

endpackage

// File: rtl/btle_skid_fifo2.sv
// Two-entry byte+last FIFO; the head entry drives the output directly so
// the output is registered and holds steady until it is popped.
module btle_skid_fifo2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push_valid,
   output logic       o_push_ready,
   input  logic [7:0] i_push_data,
   input  logic       i_push_last,
   output logic       o_pop_valid,
   input  logic       i_pop_ready,
   output logic [7:0] o_pop_data,
   output logic       o_pop_last,
   output logic [1:0] o_count
);

   logic [7:0] r_head_data;
   logic [7:0] r_tail_data;
   logic       r_head_last;
   logic       r_tail_last;
   logic [1:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign o_push_ready = (r_count != 2'd2);
   assign o_pop_valid  = (r_count != 2'd0);
   assign w_push       = i_push_valid && o_push_ready;
   assign w_pop        = o_pop_valid && i_pop_ready;
   assign o_pop_data   = r_head_data;
   assign o_pop_last   = r_head_last;
   assign o_count      = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head_data <= 8'h00;
         r_tail_data <= 8'h00;
         r_head_last <= 1'b0;
         r_tail_last <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         case (r_count)
            2'd0: begin
               if (w_push) begin
                  r_head_data <= i_push_data;
                  r_head_last <= i_push_last;
                  r_count     <= 2'd1;
               end
            end
            2'd1: begin
               if (w_push && w_pop) begin
                  r_head_data <= i_push_data;
                  r_head_last <= i_push_last;
               end else if (w_push) begin
                  r_tail_data <= i_push_data;
                  r_tail_last <= i_push_last;
                  r_count     <= 2'd2;
               end else if (w_pop) begin
                  r_count <= 2'd0;
               end
            end
            2'd2: begin
               // Full: push is refused, a pop promotes the tail entry.
               if (w_pop) begin
                  r_head_data <= r_tail_data;
                  r_head_last <= r_tail_last;
                  r_count     <= 2'd1;
               end
            end
            default: begin
               r_count <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: rtl/btle_rx_pdu_streamer.sv
// Reads a decoded PDU out of the receiver's octet memory and streams it as
// bytes with valid/ready/last, plus packet status and saturating statistics.
module btle_rx_pdu_streamer
   import btle_rx_pdu_streamer_pkg::*;
#(
   parameter bit DROP_CRC_FAIL = 1'b1,
   parameter int HDR_OCTETS    = HDR_OCTETS_C,
   parameter int MEM_ADDR_W    = MEM_ADDR_W_C,
   parameter int CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_decode_end,
   input  logic                  rx_crc_ok,
   input  logic [6:0]            rx_payload_length,
   output logic [MEM_ADDR_W-1:0] rx_pdu_octet_mem_addr,
   input  logic [7:0]            rx_pdu_octet_mem_data,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  out_crc_ok,
   output logic                  busy,
   output logic [CNT_W-1:0]      pkt_count,
   output logic [CNT_W-1:0]      crc_fail_count,
   output logic [7:0]            drop_count
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [MEM_ADDR_W-1:0] r_addr;
   logic [MEM_ADDR_W-1:0] r_last_addr;
   logic                  r_rd_pend;
   logic                  r_rd_last;
   logic                  r_crc_ok;
   logic                  r_busy;
   logic [CNT_W-1:0]      r_pkt_count;
   logic [CNT_W-1:0]      r_crc_fail_count;
   logic [7:0]            r_drop_count;

   logic [7:0]            w_n;
   logic                  w_too_long;
   logic                  w_at_last;
   logic                  w_start;
   logic                  w_issue;
   logic                  w_pop;
   logic                  w_push_ready;
   logic [1:0]            w_fifo_count;
   logic [2:0]            w_occupied;
   logic                  w_credit_ok;
   logic                  w_drop_evt;
   logic                  w_pkt_done;

   assign w_n        = {1'b0, rx_payload_length} + 8'(HDR_OCTETS);
   assign w_too_long = 32'(w_n) > (32'd1 << MEM_ADDR_W);
   assign w_at_last  = (r_addr == r_last_addr);
   assign w_pop      = out_valid && out_ready;

   // Slots held or already promised: buffered octets plus the read in flight,
   // minus the one leaving this cycle.
   assign w_occupied  = {1'b0, w_fifo_count} + {2'b00, r_rd_pend} - {2'b00, w_pop};
   assign w_credit_ok = w_push_ready && (w_occupied < 3'd2);

   assign w_drop_evt = rx_decode_end && ((r_state != ST_IDLE) || w_too_long);
   assign w_pkt_done = (r_state == ST_DRAIN) && w_pop && out_last;

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (rx_decode_end && !w_too_long && (rx_crc_ok || !DROP_CRC_FAIL)) begin
               w_start     = 1'b1;
               w_state_nxt = ST_READ;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_READ: begin
            w_issue = w_credit_ok;
            if (w_credit_ok && w_at_last) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_state_nxt = ST_READ;
            end
         end
         ST_DRAIN: begin
            if (w_pkt_done) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_addr      <= '0;
         r_last_addr <= '0;
         r_rd_pend   <= 1'b0;
         r_rd_last   <= 1'b0;
         r_crc_ok    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_rd_pend <= w_issue;
         r_rd_last <= w_issue && w_at_last;
         if (w_start) begin
            r_addr <= '0;
         end else if (w_issue) begin
            r_addr <= w_at_last ? '0 : r_addr + 1'b1;
         end
         if ((r_state == ST_IDLE) && rx_decode_end) begin
            r_crc_ok    <= rx_crc_ok;
            r_last_addr <= MEM_ADDR_W'(w_n - 8'd1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pkt_count      <= '0;
         r_crc_fail_count <= '0;
         r_drop_count     <= 8'h00;
      end else begin
         if (w_pkt_done) begin
            r_pkt_count <= CNT_W'(sat_inc(32'(r_pkt_count), CNT_W));
         end
         if ((r_state == ST_IDLE) && rx_decode_end && !rx_crc_ok) begin
            r_crc_fail_count <= CNT_W'(sat_inc(32'(r_crc_fail_count), CNT_W));
         end
         if (w_drop_evt) begin
            r_drop_count <= 8'(sat_inc(32'(r_drop_count), 8));
         end
      end
   end

   btle_skid_fifo2 u_skid (
      .clk          (clk),
      .rst          (rst),
      .i_push_valid (r_rd_pend),
      .o_push_ready (w_push_ready),
      .i_push_data  (rx_pdu_octet_mem_data),
      .i_push_last  (r_rd_last),
      .o_pop_valid  (out_valid),
      .i_pop_ready  (out_ready),
      .o_pop_data   (out_data),
      .o_pop_last   (out_last),
      .o_count      (w_fifo_count)
   );

   assign rx_pdu_octet_mem_addr = r_addr;
   assign out_crc_ok            = r_crc_ok;
   assign busy                  = r_busy;
   assign pkt_count             = r_pkt_count;
   assign crc_fail_count        = r_crc_fail_count;
   assign drop_count            = r_drop_count;

endmodule

// File: tb/tb_btle_rx_pdu_streamer.sv
// Bench for btle_rx_pdu_streamer: one instance drops CRC failures, the other
// streams them; both are fed the same packets and compared to a stream model.
module tb_btle_rx_pdu_streamer;

   localparam int AW = 6;
   localparam int CW = 16;

   typedef struct {
      int   len;
      logic crc;
      int   mode;
      logic lat;
      logic pat;
      logic exp_a;
      logic exp_drop;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       c;
      int         t;
   } oct_t;

   logic          clk = 1'b0;
   logic          rst, rx_decode_end, rx_crc_ok, out_ready;
   logic [6:0]    rx_payload_length;
   logic [AW-1:0] addr_a, addr_b;
   logic [7:0]    mdata_a, mdata_b, out_data_a, out_data_b;
   logic          out_valid_a, out_valid_b, out_last_a, out_last_b;
   logic          crc_a, crc_b, busy_a, busy_b;
   logic [CW-1:0] pkt_a, pkt_b, crcf_a, crcf_b;
   logic [7:0]    drop_a, drop_b;

   logic [7:0] mem [64];
   int   errors = 0, checks = 0, cyc = 0, ready_mode = 0, stall_left = 0;
   int   exp_pkt = 0, exp_crcf = 0, exp_drop = 0;
   oct_t qa[$], qb[$], ea[$], eb[$];
   vec_t tbl[$];
   logic pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b1;
   logic [7:0] pd = 8'h00;
   oct_t mon_o;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mdata_a <= mem[addr_a];
      mdata_b <= mem[addr_b];
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   btle_rx_pdu_streamer #(.DROP_CRC_FAIL(1'b1)) u_dut_a (
      .clk(clk), .rst(rst), .rx_decode_end(rx_decode_end), .rx_crc_ok(rx_crc_ok),
      .rx_payload_length(rx_payload_length), .rx_pdu_octet_mem_addr(addr_a),
      .rx_pdu_octet_mem_data(mdata_a), .out_data(out_data_a), .out_valid(out_valid_a),
      .out_last(out_last_a), .out_ready(out_ready), .out_crc_ok(crc_a), .busy(busy_a),
      .pkt_count(pkt_a), .crc_fail_count(crcf_a), .drop_count(drop_a));

   btle_rx_pdu_streamer #(.DROP_CRC_FAIL(1'b0)) u_dut_b (
      .clk(clk), .rst(rst), .rx_decode_end(rx_decode_end), .rx_crc_ok(rx_crc_ok),
      .rx_payload_length(rx_payload_length), .rx_pdu_octet_mem_addr(addr_b),
      .rx_pdu_octet_mem_data(mdata_b), .out_data(out_data_b), .out_valid(out_valid_b),
      .out_last(out_last_b), .out_ready(out_ready), .out_crc_ok(crc_b), .busy(busy_b),
      .pkt_count(pkt_b), .crc_fail_count(crcf_b), .drop_count(drop_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Consumer ready patterns: steady, alternating, 5-cycle stalls, coin flip.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: begin
               if (stall_left > 0) begin
                  out_ready  = 1'b0;
                  stall_left = stall_left - 1;
               end else if ($urandom_range(0, 3) == 0) begin
                  out_ready  = 1'b0;
                  stall_left = 4;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Capture accepted octets and check hold-while-stalled on instance A.
   initial forever begin
      @(negedge clk);
      if (pv && !pr && !prst) begin
         check("hold_valid", 32'(out_valid_a), 32'd1);
         check("hold_data", 32'(out_data_a), 32'(pd));
         check("hold_last", 32'(out_last_a), 32'(pl));
      end
      if (out_valid_a && out_ready) begin
         mon_o.d = out_data_a; mon_o.l = out_last_a; mon_o.c = crc_a; mon_o.t = cyc;
         qa.push_back(mon_o);
      end
      if (out_valid_b && out_ready) begin
         mon_o.d = out_data_b; mon_o.l = out_last_b; mon_o.c = crc_b; mon_o.t = cyc;
         qb.push_back(mon_o);
      end
      pv = out_valid_a; pr = out_ready; pd = out_data_a; pl = out_last_a; prst = rst;
   end

   function automatic int sat(input int v, input int maxv);
      return (v >= maxv) ? maxv : v + 1;
   endfunction

   function automatic vec_t mk(input int len, input logic crc, input int mode, input logic pat);
      vec_t v;
      v.len = len; v.crc = crc; v.mode = mode; v.pat = pat;
      v.lat      = (mode == 0);
      v.exp_drop = (len + 2 > 64);
      v.exp_a    = !v.exp_drop && crc;
      return v;
   endfunction

   task automatic fill_mem(input logic pat);
      for (int i = 0; i < 64; i++) mem[i] = pat ? 8'(i + 16) : 8'($urandom);
   endtask

   task automatic expect_pkt(input int n, input logic crc, input int t0, input logic to_a, input logic lat);
      oct_t o;
      for (int k = 0; k < n; k++) begin
         o.d = mem[k]; o.l = (k == n - 1); o.c = crc; o.t = lat ? t0 + 3 + k : -1;
         if (to_a) ea.push_back(o);
         eb.push_back(o);
      end
   endtask

   task automatic model_launch(input int n, input logic crc);
      if (!crc) exp_crcf = sat(exp_crcf, 65535);
      if (n > 64) exp_drop = sat(exp_drop, 255);
   endtask

   task automatic pulse(input int len, input logic crc, output int t0);
      @(posedge clk); #1;
      rx_decode_end = 1'b1; rx_payload_length = 7'(len); rx_crc_ok = crc; t0 = cyc;
      @(posedge clk); #1;
      rx_decode_end = 1'b0; rx_payload_length = 7'($urandom); rx_crc_ok = 1'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (i >= 4 && !busy_a && !busy_b) break;
      end
      check("idle_reached", 32'({busy_a, busy_b}), 32'd0);
      #1;
   endtask

   task automatic compare_streams(input string tag);
      check({tag, "_len_a"}, 32'(qa.size()), 32'(ea.size()));
      check({tag, "_len_b"}, 32'(qb.size()), 32'(eb.size()));
      for (int k = 0; k < ea.size() && k < qa.size(); k++) begin
         check({tag, "_data_a"}, 32'(qa[k].d), 32'(ea[k].d));
         check({tag, "_last_a"}, 32'(qa[k].l), 32'(ea[k].l));
         check({tag, "_crc_a"}, 32'(qa[k].c), 32'(ea[k].c));
         if (ea[k].t >= 0) check({tag, "_cycle_a"}, 32'(qa[k].t), 32'(ea[k].t));
      end
      for (int k = 0; k < eb.size() && k < qb.size(); k++) begin
         check({tag, "_data_b"}, 32'(qb[k].d), 32'(eb[k].d));
         check({tag, "_last_b"}, 32'(qb[k].l), 32'(eb[k].l));
         check({tag, "_crc_b"}, 32'(qb[k].c), 32'(eb[k].c));
      end
      check({tag, "_pkt_count"}, 32'(pkt_a), 32'(exp_pkt));
      check({tag, "_crc_fail_count"}, 32'(crcf_a), 32'(exp_crcf));
      check({tag, "_drop_count"}, 32'(drop_a), 32'(exp_drop));
      qa.delete(); qb.delete(); ea.delete(); eb.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(out_valid_a), 32'd0);
      check({tag, "_last"}, 32'(out_last_a), 32'd0);
      check({tag, "_data"}, 32'(out_data_a), 32'd0);
      check({tag, "_crc_ok"}, 32'(crc_a), 32'd0);
      check({tag, "_busy"}, 32'(busy_a), 32'd0);
      check({tag, "_addr"}, 32'(addr_a), 32'd0);
      check({tag, "_pkt"}, 32'(pkt_a), 32'd0);
      check({tag, "_crcf"}, 32'(crcf_a), 32'd0);
      check({tag, "_drop"}, 32'(drop_a), 32'd0);
      check({tag, "_valid_b"}, 32'(out_valid_b), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int t0, n;
      n = v.len + 2;
      ready_mode = v.mode;
      fill_mem(v.pat);
      repeat (2) @(posedge clk);
      pulse(v.len, v.crc, t0);
      model_launch(n, v.crc);
      if (!v.exp_drop) expect_pkt(n, v.crc, t0, v.exp_a, v.lat);
      if (v.exp_a) exp_pkt = sat(exp_pkt, 65535);
      if (v.exp_drop) begin
         repeat (6) begin
            @(negedge clk);
            check("drop_no_busy", 32'(busy_a), 32'd0);
            check("drop_no_read", 32'(addr_a), 32'd0);
            check("drop_no_valid", 32'(out_valid_a), 32'd0);
         end
      end
      wait_idle();
      compare_streams("vec");
      check("vec_crc_latched", 32'(crc_a), 32'(v.crc));
   endtask

   initial begin
      int t0, t1;
      rst = 1'b1; rx_decode_end = 1'b0; rx_crc_ok = 1'b0; rx_payload_length = 7'd0;
      fill_mem(1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      tbl.push_back(mk(6, 1'b1, 0, 1'b1));
      tbl.push_back(mk(6, 1'b1, 1, 1'b1));
      tbl.push_back(mk(6, 1'b1, 2, 1'b1));
      tbl.push_back(mk(6, 1'b0, 0, 1'b1));
      tbl.push_back(mk(70, 1'b1, 0, 1'b1));
      tbl.push_back(mk(0, 1'b1, 0, 1'b0));
      tbl.push_back(mk(62, 1'b1, 3, 1'b0));
      tbl.push_back(mk(63, 1'b1, 0, 1'b0));
      tbl.push_back(mk(62, 1'b1, 0, 1'b0));
      for (int i = 0; i < 14; i++)
         tbl.push_back(mk($urandom_range(0, 75), 1'($urandom_range(0, 3) != 0),
                          $urandom_range(0, 3), 1'b0));
      foreach (tbl[i]) run_vec(tbl[i]);

      // Overrun: a second pulse at T+5 must not disturb the packet in flight.
      ready_mode = 0; fill_mem(1'b1);
      repeat (2) @(posedge clk);
      pulse(6, 1'b1, t0);
      model_launch(8, 1'b1);
      expect_pkt(8, 1'b1, t0, 1'b1, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("ovr_busy", 32'(busy_a), 32'd1);
      rx_decode_end = 1'b1; rx_crc_ok = 1'b0; rx_payload_length = 7'd3;
      @(posedge clk); #1;
      rx_decode_end = 1'b0;
      exp_drop = sat(exp_drop, 255);
      exp_pkt  = sat(exp_pkt, 65535);
      wait_idle();
      compare_streams("ovr");

      // Back-to-back: new pulse in the very cycle busy falls.
      ready_mode = 0; fill_mem(1'b0);
      repeat (2) @(posedge clk);
      pulse(4, 1'b1, t0);
      model_launch(6, 1'b1);
      expect_pkt(6, 1'b1, t0, 1'b1, 1'b1);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (!busy_a) break;
      end
      check("b2b_busy_fell", 32'(busy_a), 32'd0);
      rx_decode_end = 1'b1; rx_crc_ok = 1'b1; rx_payload_length = 7'd10; t1 = cyc;
      @(posedge clk); #1;
      rx_decode_end = 1'b0;
      model_launch(12, 1'b1);
      expect_pkt(12, 1'b1, t1, 1'b1, 1'b1);
      exp_pkt = sat(sat(exp_pkt, 65535), 65535);
      wait_idle();
      compare_streams("b2b");

      // Reset at T+6 aborts the packet and clears everything.
      ready_mode = 0; fill_mem(1'b1);
      repeat (2) @(posedge clk);
      pulse(6, 1'b1, t0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_zero("midrst");
      #1;
      qa.delete(); qb.delete(); ea.delete(); eb.delete();
      exp_pkt = 0; exp_crcf = 0; exp_drop = 0;
      run_vec(mk(6, 1'b1, 0, 1'b1));
      run_vec(mk(20, 1'b1, 2, 1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
